bist_engine: RTL and testbench
==============================

# bist_engine

Test-execution end of the BIST configuration path: it reads the 13-bit BIST configuration word written through JTAG and runs the selected test. A 16-bit LFSR drives patterns into the logic under test, and a 16-bit MISR compacts the responses. The final status and signature are captured into an 18-bit result register that the TAP shifts out through TDO. It sits between the TAP instruction decode and the logic under test.

## Interface
- No parameters. Widths are fixed by the configuration word format.
- TCK  in  1  sole clock; every register updates on its rising edge.
- TRST_N  in  1  reset, asynchronous, active-low.
- BIST_CONF_REG  in  13  configuration word:
  - bit 0: mode (0 = preset test, 1 = user test).
  - [4:1]: test number.
  - [12:5]: user test length.
- START  in  1  one-cycle request from TAP (RUN-TEST/IDLE with the BIST instruction active).
- PAT_OUT  out  8  stimulus to the logic under test; equals lfsr[7:0].
- PAT_VALID  out  1  PAT_OUT carries a test pattern this cycle.
- RESP_IN  in  8  response; the response to the pattern in cycle k is presented in cycle k+1.
- BUSY  out  1  test in progress (RUN or DRAIN).
- DONE  out  1  test finished; stays high until the next accepted START.
- ERR  out  1  rejected configuration.
- SIGNATURE  out  16  MISR contents.
- RES_CAPTURE  in  1  load result shift register.
- RES_SHIFT  in  1  shift result register one bit.
- TDI  in  1  serial in.
- TDO  out  1  serial out, registered.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **Reset:** state IDLE. All outputs are 0: PAT_OUT, PAT_VALID, BUSY, DONE, ERR, SIGNATURE and TDO. The lfsr, misr, counter and result shift register are also 0.
- **START in IDLE or DONE:**
  - Snapshot BIST_CONF_REG; later config changes have no effect until the next START.
  - Clear DONE and ERR.
  - Length L:
    - preset mode: L = 16·(n+1), range 16..256.
    - user mode: L = user length, range 1..255.
  - User length 0 is illegal. The engine goes straight to DONE with ERR=1 and SIGNATURE=0, and no patterns are issued.
  - Otherwise: lfsr ← {n, 12'hA5C} (never zero), misr ← 0, 9-bit counter ← L, state → RUN.
- **START in RUN or DRAIN:** ignored.
- **RUN:**
  - PAT_VALID=1.
  - Each cycle, the LFSR advances: lfsr ← {lfsr[14:0], fb}, with fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - The counter decrements each cycle. When the counter reaches 1, the next state is DRAIN.
- **MISR:**
  - On every edge where the previous cycle had PAT_VALID=1: misr ← {misr[14:0], mfb} ^ {8'h00, RESP_IN}, with mfb using the same taps on misr.
  - Exactly L compactions per test. SIGNATURE = misr at all times.
- **DRAIN:** one cycle. PAT_VALID=0; the last response is compacted. Next state is DONE.
- **DONE:** DONE=1, BUSY=0. The state holds until START.
- **Result shift register (18 bits):**
  - RES_CAPTURE: sr ← {SIGNATURE, ERR, DONE}.
  - Else RES_SHIFT: TDO ← sr[0], sr ← {TDI, sr[17:1]}. This is LSB-first, the same convention as the configuration register.
  - RES_CAPTURE has priority over RES_SHIFT.
  - The result register operates in every FSM state and does not disturb the test.

## Timing
- Edge 0 is the edge that samples START.
- PAT_VALID is high in cycles 1..L. PAT_OUT in cycle 1 = seed[7:0].
- Responses are compacted at edges 2..L+1.
- DRAIN is cycle L+1. DONE rises after edge L+1. BUSY is high in cycles 1..L+1.
- Error path: DONE=1 and ERR=1 from cycle 1; BUSY never asserts.
- TRST_N assertion mid-test aborts immediately to reset values; no partial result is retained.
- TDO changes only on a shift edge.

## Structure
- The shared package bist_pkg holds:
  - config field positions: MODE_BIT=0, TNUM=[4:1], ULEN=[12:5].
  - state encoding.
  - tap mask 16'hB400.
  - seed constant 12'hA5C.
  - RESULT_W=18.
- One sub-module, bist_misr: the 16-bit compactor with enable, clear and 8-bit parallel input. The LFSR stays inline.

## Test plan
- **Reset:** assert TRST_N=0 mid-RUN → all outputs 0 asynchronously; after release, state is IDLE and PAT_VALID stays 0.
- **Preset test 0, RESP_IN=0:**
  - PAT_VALID high exactly 16 cycles.
  - PAT_OUT = 8'h5C, then 8'hB8.
  - DONE rises after edge 17.
  - SIGNATURE=16'h0000, ERR=0.
- **User mode, length 3, RESP_IN=8'h01 constant** → 3 patterns, SIGNATURE=16'h0007, DONE=1.
- **User mode, length 0** → ERR=1 and DONE=1 in cycle 1, PAT_VALID never high, BUSY never high.
- **Preset test 15** → PAT_VALID high 256 cycles (counter boundary). A START pulse mid-run is ignored. BIST_CONF_REG changes mid-run do not alter the length.
- **Readout after the length-3 run:** RES_CAPTURE, then 18 RES_SHIFT → TDO sequence 1,0,1,1,1,0,…,0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engine: configuration word layout, FSM encoding,
// LFSR/MISR tap polynomial, seed constant and result register width.
package bist_pkg;

    localparam int CONF_W   = 13;
    localparam int MODE_BIT = 0;
    localparam int TNUM_LSB = 1;
    localparam int TNUM_MSB = 4;
    localparam int ULEN_LSB = 5;
    localparam int ULEN_MSB = 12;
    localparam int RESULT_W = 18;

    localparam logic [15:0] TAP_MASK = 16'hB400;
    localparam logic [11:0] SEED_LO  = 12'hA5C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Feedback bit: parity of taps 15, 13, 12 and 10.
    function automatic logic tap_fb(input logic [15:0] v);
        return ^(v & TAP_MASK);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with an 8-bit parallel input.
// Clear wins over enable; one compaction per enabled edge, no backpressure.
module bist_misr
    import bist_pkg::*;
(
    input  logic        TCK,
    input  logic        TRST_N,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] sig
);

    logic [15:0] misr_q;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            misr_q <= 16'h0000;
        end else if (clr) begin
            misr_q <= 16'h0000;
        end else if (en) begin
            misr_q <= {misr_q[14:0], tap_fb(misr_q)} ^ {8'h00, din};
        end
    end

    assign sig = misr_q;

endmodule

// File: rtl/bist_engine.sv
// BIST test executor: LFSR stimulus for L cycles, MISR compaction one cycle behind,
// 18-bit result register shifted out LSB-first through TDO.
module bist_engine
    import bist_pkg::*;
(
    input  logic              TCK,
    input  logic              TRST_N,
    input  logic [CONF_W-1:0] BIST_CONF_REG,
    input  logic              START,
    output logic [7:0]        PAT_OUT,
    output logic              PAT_VALID,
    input  logic [7:0]        RESP_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [15:0]       SIGNATURE,
    input  logic              RES_CAPTURE,
    input  logic              RES_SHIFT,
    input  logic              TDI,
    output logic              TDO
);

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q;
    logic [8:0]            cnt_q;
    logic                  err_q;
    logic                  pv_d_q;
    logic [RESULT_W-1:0]   sr_q;
    logic                  tdo_q;

    logic                  cfg_mode;
    logic [3:0]            cfg_tnum;
    logic [7:0]            cfg_ulen;
    logic [4:0]            tnum_p1;
    logic [8:0]            test_len;
    logic                  bad_len;

    logic                  load;
    logic                  misr_clr;
    logic                  err_set;
    logic                  pat_valid;
    logic                  busy;
    logic                  done;

    assign cfg_mode = BIST_CONF_REG[MODE_BIT];
    assign cfg_tnum = BIST_CONF_REG[TNUM_MSB:TNUM_LSB];
    assign cfg_ulen = BIST_CONF_REG[ULEN_MSB:ULEN_LSB];
    assign tnum_p1  = {1'b0, cfg_tnum} + 5'd1;
    assign test_len = cfg_mode ? {1'b0, cfg_ulen} : {tnum_p1, 4'b0000};
    assign bad_len  = cfg_mode && (cfg_ulen == 8'd0);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        misr_clr  = 1'b0;
        err_set   = 1'b0;
        pat_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (START) begin
                    misr_clr = 1'b1;
                    if (bad_len) begin
                        err_set = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                pat_valid = 1'b1;
                busy      = 1'b1;
                if (cnt_q == 9'd1) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The configuration is consumed only at an accepted START, so later edits are inert.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            lfsr_q <= 16'h0000;
            cnt_q  <= 9'd0;
            err_q  <= 1'b0;
            pv_d_q <= 1'b0;
        end else begin
            pv_d_q <= pat_valid;
            if (misr_clr) begin
                err_q <= err_set;
            end
            if (load) begin
                lfsr_q <= {cfg_tnum, SEED_LO};
                cnt_q  <= test_len;
            end else if (state_q == ST_RUN) begin
                lfsr_q <= {lfsr_q[14:0], tap_fb(lfsr_q)};
                cnt_q  <= cnt_q - 9'd1;
            end
        end
    end

    // Responses arrive one cycle after their pattern, hence the delayed valid as enable.
    bist_misr u_misr (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .clr    (misr_clr),
        .en     (pv_d_q),
        .din    (RESP_IN),
        .sig    (SIGNATURE)
    );

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            sr_q  <= '0;
            tdo_q <= 1'b0;
        end else if (RES_CAPTURE) begin
            sr_q <= {SIGNATURE, err_q, done};
        end else if (RES_SHIFT) begin
            tdo_q <= sr_q[0];
            sr_q  <= {TDI, sr_q[RESULT_W-1:1]};
        end
    end

    assign PAT_OUT   = lfsr_q[7:0];
    assign PAT_VALID = pat_valid;
    assign BUSY      = busy;
    assign DONE      = done;
    assign ERR       = err_q;
    assign TDO       = tdo_q;

endmodule

// File: tb/tb_bist_engine.sv
// Directed + randomized bench for bist_engine against a queue-based reference model.
module tb_bist_engine;

    logic        TCK = 1'b0;
    logic        TRST_N = 1'b0;
    logic [12:0] BIST_CONF_REG = '0;
    logic        START = 1'b0;
    logic [7:0]  PAT_OUT;
    logic        PAT_VALID;
    logic [7:0]  RESP_IN = '0;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] SIGNATURE;
    logic        RES_CAPTURE = 1'b0;
    logic        RES_SHIFT = 1'b0;
    logic        TDI = 1'b0;
    logic        TDO;

    int checks = 0;
    int failures = 0;

    bist_engine dut (
        .TCK           (TCK),
        .TRST_N        (TRST_N),
        .BIST_CONF_REG (BIST_CONF_REG),
        .START         (START),
        .PAT_OUT       (PAT_OUT),
        .PAT_VALID     (PAT_VALID),
        .RESP_IN       (RESP_IN),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR           (ERR),
        .SIGNATURE     (SIGNATURE),
        .RES_CAPTURE   (RES_CAPTURE),
        .RES_SHIFT     (RES_SHIFT),
        .TDI           (TDI),
        .TDO           (TDO)
    );

    always #5 TCK = ~TCK;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] r);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {8'h00, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b000, PAT_OUT, PAT_VALID, BUSY, DONE, ERR, SIGNATURE, TDO};
    endfunction

    // Runs one test from START to a few cycles past completion and checks it end to end.
    task automatic run_test(input string tag, input logic mode, input logic [3:0] n,
                            input logic [7:0] ulen, input bit rand_resp,
                            input logic [7:0] resp_const, input int disturb,
                            output logic [15:0] sig_exp,
                            output logic [7:0] pat1, output logic [7:0] pat2);
        int          len;
        bit          err_exp;
        logic [15:0] p;
        logic [7:0]  resp_q[$];
        int          pv_n, busy_n, done_first, pat_bad;
        err_exp = mode && (ulen == 8'd0);
        len = err_exp ? 0 : (mode ? int'(ulen) : 16 * (int'(n) + 1));
        p = {n, 12'hA5C};
        pv_n = 0; busy_n = 0; done_first = -1; pat_bad = 0;
        pat1 = '0; pat2 = '0;
        BIST_CONF_REG = {ulen, n, mode};
        START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 1; c <= len + 3; c++) begin
            if (c <= len) begin
                if (PAT_OUT !== p[7:0]) pat_bad++;
                if (c == 1) pat1 = PAT_OUT;
                if (c == 2) pat2 = PAT_OUT;
                p = lfsr_step(p);
            end
            if (PAT_VALID === 1'b1) pv_n++;
            if (BUSY === 1'b1) busy_n++;
            if (DONE === 1'b1 && done_first < 0) done_first = c;
            RESP_IN = rand_resp ? 8'($urandom) : resp_const;
            if (c >= 2 && c <= len + 1) resp_q.push_back(RESP_IN);
            if (disturb > 0 && c == disturb) begin
                START = 1'b1;
                BIST_CONF_REG = {8'd5, 4'd0, 1'b1};
            end else begin
                START = 1'b0;
            end
            step();
        end
        sig_exp = 16'h0000;
        foreach (resp_q[i]) sig_exp = misr_step(sig_exp, resp_q[i]);
        chk({tag, "/pv_cycles"}, 32'(pv_n), 32'(len));
        chk({tag, "/busy_cycles"}, 32'(busy_n), err_exp ? 32'd0 : 32'(len + 1));
        chk({tag, "/done_cycle"}, 32'(done_first), err_exp ? 32'd1 : 32'(len + 2));
        chk({tag, "/pattern_errs"}, 32'(pat_bad), 32'd0);
        chk({tag, "/signature"}, 32'(SIGNATURE), 32'(sig_exp));
        chk({tag, "/err"}, 32'(ERR), 32'(err_exp));
        chk({tag, "/done"}, 32'(DONE), 32'd1);
    endtask

    // Capture (with SHIFT also high to exercise priority), then shift out 18 bits.
    task automatic readout(input string tag, input logic [17:0] exp);
        logic        tdo_before;
        logic [17:0] got;
        tdo_before = TDO;
        RES_CAPTURE = 1'b1;
        RES_SHIFT = 1'b1;
        step();
        RES_CAPTURE = 1'b0;
        chk({tag, "/tdo_hold_on_capture"}, 32'(TDO), 32'(tdo_before));
        for (int i = 0; i < 18; i++) begin
            TDI = 1'($urandom);
            step();
            got[i] = TDO;
        end
        RES_SHIFT = 1'b0;
        chk({tag, "/tdo_stream"}, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [15:0] sig;
        logic [7:0]  p1, p2;
        logic [3:0]  rn;
        logic [7:0]  ru;
        logic        rm;

        #2;
        chk("reset/outputs", all_outs(), 32'd0);
        step();
        step();
        TRST_N = 1'b1;
        step();
        chk("idle/pv_busy_done", {29'd0, PAT_VALID, BUSY, DONE}, 32'd0);

        run_test("preset0", 1'b0, 4'd0, 8'd0, 1'b0, 8'h00, 0, sig, p1, p2);
        chk("preset0/pat1", 32'(p1), 32'h5C);
        chk("preset0/pat2", 32'(p2), 32'hB8);
        chk("preset0/sig_zero", 32'(SIGNATURE), 32'h0000);

        run_test("user3", 1'b1, 4'd0, 8'd3, 1'b0, 8'h01, 0, sig, p1, p2);
        chk("user3/sig_const", 32'(SIGNATURE), 32'h0007);
        readout("user3_rd", 18'h0001D);

        run_test("user0", 1'b1, 4'd7, 8'd0, 1'b1, 8'h00, 0, sig, p1, p2);
        chk("user0/sig_zero", 32'(SIGNATURE), 32'h0000);
        readout("user0_rd", 18'h00003);

        run_test("preset15", 1'b0, 4'd15, 8'd0, 1'b1, 8'h00, 40, sig, p1, p2);

        for (int k = 0; k < 3; k++) begin
            rm = 1'($urandom);
            rn = 4'($urandom);
            ru = 8'($urandom_range(255, 1));
            run_test("random", rm, rn, ru, 1'b1, 8'h00, 0, sig, p1, p2);
            readout("random_rd", {sig, 1'b0, 1'b1});
        end

        // Reset in the middle of a running test.
        BIST_CONF_REG = {8'd0, 4'd2, 1'b0};
        START = 1'b1;
        step();
        START = 1'b0;
        for (int c = 0; c < 6; c++) begin
            RESP_IN = 8'($urandom_range(255, 1));
            step();
        end
        chk("midrun/busy_before_reset", 32'(BUSY), 32'd1);
        #2;
        TRST_N = 1'b0;
        #1;
        chk("midrun/async_reset_outputs", all_outs(), 32'd0);
        #3;
        TRST_N = 1'b1;
        step();
        step();
        step();
        chk("midrun/idle_after_release", {29'd0, PAT_VALID, BUSY, DONE}, 32'd0);
        chk("midrun/sig_after_release", 32'(SIGNATURE), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
